// File: rtl/serial_frame_rx.sv
// serial_frame_rx: frames qualified serial bits into words.
// Start(1), WIDTH data MSB first, even parity, stop(0).
//
// Ports:
//   clk, reset  rising clock, sync active-high reset
//   bit_valid   qualifies bit_in on an edge
//   bit_in      serial data from the upstream stage
//   out_data    received word, stable while out_valid
//   out_valid   word available to the consumer
//   out_ready   consumer accepts on out_valid & out_ready
//   parity_err  1-cycle pulse, word dropped
//   frame_err   1-cycle pulse, word dropped
//   overrun     sticky: good word lost to a full output
//   busy        receiver is inside a frame
module serial_frame_rx #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    STOP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             good;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    good    = 1'b0;
    if (bit_valid) begin
      unique case (state_q)
        IDLE: begin
          if (bit_in) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          sr_d  = {sr_q[WIDTH-2:0], bit_in};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (bit_in == ^sr_q) begin
            state_d = STOP;
          end else begin
            perr_d  = 1'b1;
            state_d = IDLE;
          end
        end
        STOP: begin
          state_d = IDLE;
          if (bit_in) ferr_d = 1'b1;
          else        good   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output slot: a pop this cycle frees room for a new word.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (good) begin
      if (!valid_q || out_ready) begin
        data_d  = sr_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: scoreboard bench for serial_frame_rx.
// Words and error events are queued; a monitor checks them.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_valid;
  logic       bit_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  byte        evt_q[$];

  serial_frame_rx #(.WIDTH(8), .PARITY_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  // Monitor: samples on negedge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word: got %0h, want none", out_data);
        end else begin
          logic [7:0] w;
          w = exp_q.pop_front();
          if (out_data !== w) begin
            errors++;
            $display("FAIL word: got %0h, want %0h",
                     out_data, w);
          end
        end
      end
      if (parity_err) begin
        checks++;
        if (evt_q.size() == 0 || evt_q[0] != "P") begin
          errors++;
          $display("FAIL parity_err: got pulse, want none");
        end else void'(evt_q.pop_front());
      end
      if (frame_err) begin
        checks++;
        if (evt_q.size() == 0 || evt_q[0] != "F") begin
          errors++;
          $display("FAIL frame_err: got pulse, want none");
        end else void'(evt_q.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic b);
    @(posedge clk);
    #2;
    bit_valid = v;
    bit_in    = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0);
  endtask

  task automatic frame(input logic [7:0] w,
                       input logic       pflip,
                       input logic       stopb,
                       input logic       gap);
    logic [10:0] bits;
    bits = {1'b1, w, (^w) ^ pflip, stopb};
    for (int i = 10; i >= 0; i--) begin
      drive(1'b1, bits[i]);
      if (gap) drive(1'b0, ~bits[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data", 32'(out_data), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst overrun", 32'(overrun), 0);
    reset = 1'b0;
    idle(3);

    // 1: good 0xA5, exact latency
    exp_q.push_back(8'hA5);
    frame(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("t1 busy", 32'(busy), 1);
    idle(1);
    chk("t1 valid", 32'(out_valid), 1);
    chk("t1 data", 32'(out_data), 32'hA5);
    idle(1);
    chk("t1 valid drop", 32'(out_valid), 0);
    idle(2);

    // 2: parity error then good 0x3C
    evt_q.push_back("P");
    frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("t2 no valid", 32'(out_valid), 0);
    exp_q.push_back(8'h3C);
    frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("t2 data", 32'(out_data), 32'h3C);
    idle(2);

    // 3: stop error
    evt_q.push_back("F");
    frame(8'hA5, 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("t3 no valid", 32'(out_valid), 0);
    chk("t3 busy", 32'(busy), 0);

    // 4: backpressure and overrun
    out_ready = 1'b0;
    exp_q.push_back(8'h11);
    frame(8'h11, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("t4 ovr early", 32'(overrun), 0);
    frame(8'h22, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("t4 data", 32'(out_data), 32'h11);
    chk("t4 valid", 32'(out_valid), 1);
    chk("t4 overrun", 32'(overrun), 1);
    out_ready = 1'b1;
    idle(1);
    chk("t4 valid drop", 32'(out_valid), 0);
    chk("t4 ovr sticky", 32'(overrun), 1);
    idle(2);

    // 5: gapped bits, leading idle zeros
    idle(4);
    chk("t5 idle busy", 32'(busy), 0);
    exp_q.push_back(8'h5A);
    frame(8'h5A, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("t5 data", 32'(out_data), 32'h5A);
    idle(2);

    // 6: reset mid-frame
    drive(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    bit_valid = 1'b1;
    bit_in = 1'b0;
    chk("t6 valid", 32'(out_valid), 0);
    chk("t6 data", 32'(out_data), 0);
    chk("t6 busy", 32'(busy), 0);
    chk("t6 overrun", 32'(overrun), 0);
    chk("t6 perr", 32'(parity_err), 0);
    chk("t6 ferr", 32'(frame_err), 0);
    idle(2);
    exp_q.push_back(8'hC3);
    frame(8'hC3, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("t6 data C3", 32'(out_data), 32'hC3);
    idle(4);

    chk("words left", 32'(exp_q.size()), 0);
    chk("events left", 32'(evt_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
